// File: rtl/snpu_entropy_pool.sv
// Entropy pool: 2-flop sync, masked XOR fold every DIV clks, repetition-count health test, pack to W-bit words, FWFT FIFO.
// Word visible 1 clk after its last bit; full FIFO without same-cycle pop drops the word (sticky overflow). Optional SNPU_VN_DEBIAS_EN.
module snpu_entropy_pool #(
    parameter int N_CH      = 32,
    parameter int W         = 16,
    parameter int DEPTH     = 4,
    parameter int DIV       = 4,
    parameter int RCT_LIMIT = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_CH-1:0]          raw_in_i,
    input  logic [N_CH-1:0]          ch_mask_i,
    input  logic                     freeze_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [W-1:0]             out_data_o,
    output logic [$clog2(DEPTH):0]   fill_level_o,
    output logic                     overflow_o,
    output logic                     health_fail_o,
    input  logic                     health_clr_i
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam int CW = $clog2(W);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(RCT_LIMIT);
    localparam logic [CW-1:0] CNT_MAX   = CW'(W - 1);
    localparam logic [AW:0]   FILL_MAX  = (AW + 1)'(DEPTH);

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [RW-1:0]   run_q, run_d, run_inc, run_nx;
    logic            last_q, last_d;
    logic [W-1:0]    acc_q, acc_d, acc_sh;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hf_q, hf_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     fill_q, fill_d;

    logic tick, sample, fbit, trip, accept, emit, ebit, push, push_ok, pop, drop;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!freeze_i) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign sample  = tick && (|ch_mask_i);
    assign fbit    = ^(sync2_q & ch_mask_i);
    assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    assign run_nx  = (fbit == last_q) ? run_inc : RW'(1);
    // A clear in the same cycle as a trip cancels the trip and its side effects.
    assign trip    = sample && (run_nx == RUN_MAX) && !health_clr_i;
    assign accept  = sample && !trip && !hf_q;

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (sample) begin
            run_d  = run_nx;
            last_d = fbit;
        end
        if (health_clr_i) begin
            run_d = '0;
        end
        hf_d = health_clr_i ? 1'b0 : (hf_q | trip);
    end

`ifdef SNPU_VN_DEBIAS_EN
    logic pend_q, pend_d, half_q, half_d;

    always_comb begin
        pend_d = pend_q;
        half_d = half_q;
        emit   = 1'b0;
        ebit   = half_q;
        if (trip) begin
            pend_d = 1'b0;
        end else if (accept) begin
            if (!pend_q) begin
                pend_d = 1'b1;
                half_d = fbit;
            end else begin
                pend_d = 1'b0;
                emit   = (half_q != fbit);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend_q <= 1'b0;
            half_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            half_q <= half_d;
        end
    end
`else
    assign emit = accept;
    assign ebit = fbit;
`endif

    assign acc_sh = {acc_q[W-2:0], ebit};

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        if (trip) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (emit) begin
            acc_d = acc_sh;
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                push  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign out_valid_o = (fill_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign push_ok     = push && ((fill_q != FILL_MAX) || pop);
    assign drop        = push && !push_ok;

    always_comb begin
        wr_d   = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        fill_d = fill_q;
        if (push_ok && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (!push_ok && pop) begin
            fill_d = fill_q - 1'b1;
        end
        ovf_d = health_clr_i ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hf_q    <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_in_i;
            sync2_q <= sync1_q;
            presc_q <= presc_d;
            run_q   <= run_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hf_q    <= hf_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            if (push_ok) begin
                mem_q[wr_q] <= acc_sh;
            end
        end
    end

    assign out_data_o    = out_valid_o ? mem_q[rd_q] : '0;
    assign fill_level_o  = fill_q;
    assign overflow_o    = ovf_q;
    assign health_fail_o = hf_q;

endmodule

// File: tb/tb_snpu_entropy_pool.sv
// Directed bench for snpu_entropy_pool with DIV=1 (one tick per clk while unfrozen).
module tb_snpu_entropy_pool;

    localparam logic [63:0] ALT  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] raw_in = '0;
    logic [31:0] ch_mask = '0;
    logic        freeze = 1'b0;
    logic        out_ready = 1'b0;
    logic        health_clr = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  fill_level;
    logic        overflow;
    logic        health_fail;

    int checks = 0;
    int failures = 0;

    logic [15:0] words [5];

    snpu_entropy_pool #(
        .N_CH(32), .W(16), .DEPTH(4), .DIV(1), .RCT_LIMIT(32)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .raw_in_i      (raw_in),
        .ch_mask_i     (ch_mask),
        .freeze_i      (freeze),
        .out_ready_i   (out_ready),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .fill_level_o  (fill_level),
        .overflow_o    (overflow),
        .health_fail_o (health_fail),
        .health_clr_i  (health_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // b[i] is the channel value at tick i; the mask opens two clks late to cover the sync delay.
    task automatic stream(input logic [63:0] b0, input logic [63:0] b1, input int n,
                          input logic [31:0] m, input bit pop_last);
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i < n) raw_in = {30'b0, b1[i], b0[i]};
            ch_mask   = (i >= 2) ? m : 32'h0;
            out_ready = pop_last && (i == n + 1);
        end
        @(negedge clk);
        ch_mask   = '0;
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] bits_of(input logic [15:0] w);
        logic [63:0] b = '0;
        for (int i = 0; i < 16; i++) b[i] = w[15 - i];
        return b;
    endfunction

    task automatic send_word(input logic [15:0] w, input bit pop_last);
        stream(bits_of(w), 64'h0, 16, 32'h1, pop_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ch_mask = '0; raw_in = '0; freeze = 1'b0;
        out_ready = 1'b0; health_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        health_clr = 1'b1;
        @(negedge clk);
        health_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({out_valid, fill_level, overflow, health_fail} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got valid=%b fill=%0d ovf=%b hf=%b, want all 0",
                     out_valid, fill_level, overflow, health_fail);
        end
        checks++;
        if (out_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0000", out_data);
        end
    endtask

    task automatic test_alt();
        do_reset();
`ifdef SNPU_VN_DEBIAS_EN
        stream(ALT, 64'h0, 31, 32'h1, 1'b0);
`else
        stream(ALT, 64'h0, 15, 32'h1, 1'b0);
`endif
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL alt_partial: got valid=%b want 0", out_valid);
        end
        stream(64'h0, 64'h0, 1, 32'h1, 1'b0);
        checks++;
        if ({out_valid, fill_level} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL alt_fill: got valid=%b fill=%0d want 1/1", out_valid, fill_level);
        end
        checks++;
`ifdef SNPU_VN_DEBIAS_EN
        if (out_data !== 16'hFFFF) begin
            failures++;
            $display("FAIL alt_word: got %h want FFFF", out_data);
        end
`else
        if (out_data !== 16'hAAAA) begin
            failures++;
            $display("FAIL alt_word: got %h want AAAA", out_data);
        end
`endif
        pop_n(1);
        checks++;
        if ({out_valid, out_data} !== 17'h0) begin
            failures++;
            $display("FAIL alt_empty: got valid=%b data=%h want 0/0000", out_valid, out_data);
        end
    endtask

    task automatic test_fold();
        do_reset();
        stream(ONES, ALT, 8, 32'h3, 1'b0);
        repeat (50) @(negedge clk);
        checks++;
        if ({out_valid, fill_level} !== 4'b0) begin
            failures++;
            $display("FAIL fold_idle: got valid=%b fill=%0d want 0/0", out_valid, fill_level);
        end
        stream(ONES, ALT, 8, 32'h3, 1'b0);
        checks++;
        if ({out_valid, fill_level, out_data} !== {1'b1, 3'd1, 16'h5555}) begin
            failures++;
            $display("FAIL fold_word: got valid=%b fill=%0d data=%h want 1/1/5555",
                     out_valid, fill_level, out_data);
        end
    endtask

    task automatic test_health();
        do_reset();
        stream(64'h0, 64'h0, 31, 32'h1, 1'b0);
        checks++;
        if ({health_fail, fill_level, out_data} !== {1'b0, 3'd1, 16'h0000}) begin
            failures++;
            $display("FAIL health_31: got hf=%b fill=%0d data=%h want 0/1/0000",
                     health_fail, fill_level, out_data);
        end
        stream(64'h0, 64'h0, 1, 32'h1, 1'b0);
        checks++;
        if ({health_fail, fill_level} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL health_trip: got hf=%b fill=%0d want 1/1", health_fail, fill_level);
        end
        pop_n(1);
        stream(ALT, 64'h0, 16, 32'h1, 1'b0);
        checks++;
        if ({health_fail, fill_level} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL health_block: got hf=%b fill=%0d want 1/0", health_fail, fill_level);
        end
        pulse_clr();
        checks++;
        if (health_fail !== 1'b0) begin
            failures++;
            $display("FAIL health_clr: got hf=%b want 0", health_fail);
        end
        send_word(16'hAAAA, 1'b0);
        checks++;
        if ({health_fail, fill_level, out_data} !== {1'b0, 3'd1, 16'hAAAA}) begin
            failures++;
            $display("FAIL health_recover: got hf=%b fill=%0d data=%h want 0/1/AAAA",
                     health_fail, fill_level, out_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) send_word(words[k], 1'b0);
        checks++;
        if ({fill_level, overflow} !== {3'd4, 1'b0}) begin
            failures++;
            $display("FAIL ovf_full: got fill=%0d ovf=%b want 4/0", fill_level, overflow);
        end
        send_word(words[4], 1'b0);
        checks++;
        if ({fill_level, overflow} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL ovf_drop: got fill=%0d ovf=%b want 4/1", fill_level, overflow);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, words[k]}) begin
                failures++;
                $display("FAIL ovf_drain%0d: got valid=%b data=%h want 1/%h",
                         k, out_valid, out_data, words[k]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, out_data, fill_level, overflow} !== {1'b0, 16'h0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_empty: got valid=%b data=%h fill=%0d ovf=%b want 0/0000/0/1",
                     out_valid, out_data, fill_level, overflow);
        end
        pulse_clr();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr: got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int k = 0; k < 4; k++) send_word(words[k], 1'b0);
        send_word(words[4], 1'b1);
        checks++;
        if ({fill_level, overflow, out_data} !== {3'd4, 1'b0, words[1]}) begin
            failures++;
            $display("FAIL pushpop: got fill=%0d ovf=%b head=%h want 4/0/%h",
                     fill_level, overflow, out_data, words[1]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (out_data !== words[k]) begin
                failures++;
                $display("FAIL pushpop_drain%0d: got %h want %h", k, out_data, words[k]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        stream(bits_of(16'hC3A5), 64'h0, 8, 32'h1, 1'b0);
        @(negedge clk);
        freeze  = 1'b1;
        ch_mask = 32'h1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            raw_in[0] = ~raw_in[0];
        end
        checks++;
        if ({out_valid, fill_level} !== 4'b0) begin
            failures++;
            $display("FAIL freeze_hold: got valid=%b fill=%0d want 0/0", out_valid, fill_level);
        end
        ch_mask = '0;
        @(negedge clk);
        freeze = 1'b0;
        stream(bits_of(16'hA500), 64'h0, 8, 32'h1, 1'b0);
        checks++;
        if ({out_valid, fill_level, out_data} !== {1'b1, 3'd1, 16'hC3A5}) begin
            failures++;
            $display("FAIL freeze_word: got valid=%b fill=%0d data=%h want 1/1/C3A5",
                     out_valid, fill_level, out_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) send_word(words[k], 1'b0);
        pop_n(2);
        stream(bits_of(16'h5A00), 64'h0, 8, 32'h1, 1'b0);
        checks++;
        if ({fill_level, overflow} !== {3'd2, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_pre: got fill=%0d ovf=%b want 2/1", fill_level, overflow);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({out_valid, fill_level, overflow, health_fail, out_data} !== 22'h0) begin
            failures++;
            $display("FAIL rstmid_clear: got valid=%b fill=%0d ovf=%b hf=%b data=%h want all 0",
                     out_valid, fill_level, overflow, health_fail, out_data);
        end
        send_word(16'h3C5A, 1'b0);
        checks++;
        if ({fill_level, out_data} !== {3'd1, 16'h3C5A}) begin
            failures++;
            $display("FAIL rstmid_fresh: got fill=%0d data=%h want 1/3C5A", fill_level, out_data);
        end
    endtask

    initial begin
        words[0] = 16'hA5C3;
        words[1] = 16'h3C5A;
        words[2] = 16'h9669;
        words[3] = 16'h6996;
        words[4] = 16'hF00F;
        test_reset();
        test_alt();
`ifndef SNPU_VN_DEBIAS_EN
        test_fold();
        test_health();
        test_overflow();
        test_push_pop();
        test_freeze();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
